// File: rtl/vedic_mac_seq_pkg.sv
// Shared definitions for the Vedic multiply-accumulate front end:
// operand/product widths, default timing, FSM encoding and the
// Urdhva-Tiryakbhyam building blocks used by the multiplier.
package vedic_mac_seq_pkg;

   localparam int OP_W       = 8;
   localparam int PROD_W     = 16;
   localparam int SETTLE_DEF = 11;
   localparam int ACC_W_DEF  = 24;
   localparam int CNT_W_DEF  = 8;

   // Pipeline depth of vedic8x8; SETTLE must be at least MULT_LAT + 1.
   localparam int MULT_LAT   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      OUT  = 2'd2
   } state_t;

   // 2x2 vertical-and-crosswise product built from two half adders.
   function automatic logic [3:0] vedic2x2(input logic [1:0] a, input logic [1:0] b);
      logic hi;
      logic cross_c;
      hi      = a[1] & b[1];
      cross_c = (a[1] & b[0]) & (a[0] & b[1]);
      return {hi & cross_c, hi ^ cross_c, (a[1] & b[0]) ^ (a[0] & b[1]), a[0] & b[0]};
   endfunction

   // 4x4 product from four 2x2 blocks; the two cross terms share one add.
   function automatic logic [7:0] vedic4x4(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] ll;
      logic [3:0] hl;
      logic [3:0] lh;
      logic [3:0] hh;
      logic [4:0] mid;
      ll  = vedic2x2(a[1:0], b[1:0]);
      hl  = vedic2x2(a[3:2], b[1:0]);
      lh  = vedic2x2(a[1:0], b[3:2]);
      hh  = vedic2x2(a[3:2], b[3:2]);
      mid = {1'b0, hl} + {1'b0, lh};
      return {4'b0000, ll} + {1'b0, mid, 2'b00} + {hh, 4'b0000};
   endfunction

endpackage

// File: rtl/vedic_mac_seq_if.sv
// Operand stream in, group result out. The block itself connects as the
// slave; the operand source / result consumer side uses master.
interface vedic_mac_seq_if
   import vedic_mac_seq_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
);

   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   in_a;
   logic [OP_W-1:0]   in_b;
   logic              in_last;

   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_acc;
   logic              out_ovf;
   logic [CNT_W-1:0]  out_count;

   modport master (
      output in_valid, in_a, in_b, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_ovf, out_count
   );

   modport slave (
      input  in_valid, in_a, in_b, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_ovf, out_count
   );

endinterface

// File: rtl/vedic_mac_seq_vedic8x8.sv
// 8x8 Vedic multiplier, two register stages. Stage one forms the four
// 4x4 partial products, stage two merges them. Operands must be held
// stable for MULT_LAT edges before the product is meaningful.
module vedic8x8
   import vedic_mac_seq_pkg::*;
(
   input  logic [OP_W-1:0]   op_a,
   input  logic [OP_W-1:0]   op_b,
   input  logic              clk,
   output logic [PROD_W-1:0] product
);

   logic [7:0] pp_ll;
   logic [7:0] pp_hl;
   logic [7:0] pp_lh;
   logic [7:0] pp_hh;
   logic [8:0] mid_sum;

   // Stage 1: vertical and crosswise 4x4 partial products.
   always_ff @(posedge clk) begin
      pp_ll <= vedic4x4(op_a[3:0], op_b[3:0]);
      pp_hl <= vedic4x4(op_a[7:4], op_b[3:0]);
      pp_lh <= vedic4x4(op_a[3:0], op_b[7:4]);
      pp_hh <= vedic4x4(op_a[7:4], op_b[7:4]);
   end

   assign mid_sum = {1'b0, pp_hl} + {1'b0, pp_lh};

   // Stage 2: shift-and-add the partial products into the full product.
   always_ff @(posedge clk) begin
      product <= {8'h00, pp_ll} + {3'b000, mid_sum, 4'h0} + {pp_hh, 8'h00};
   end

endmodule

// File: rtl/vedic_mac_seq.sv
// Sequential MAC front end for vedic8x8. Takes one operand pair at a time,
// holds it on the multiplier for SETTLE edges, accumulates the product and
// presents the group sum when the pair tagged last has been added.
//
//   state | meaning
//   IDLE  | ready for the next operand pair (in_ready=1)
//   WAIT  | pair held on the multiplier, settle counter running
//   OUT   | group result presented, waiting for out_ready
module vedic_mac_seq
   import vedic_mac_seq_pkg::*;
#(
   parameter int SETTLE = SETTLE_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
)(
   input  logic          clk,
   input  logic          rst,
   vedic_mac_seq_if.slave bus
);

   localparam int              SC_W    = $clog2(SETTLE + 1);
   localparam logic [SC_W-1:0] SC_TC   = SC_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state;
   state_t            state_nx;

   logic [OP_W-1:0]   op_a;
   logic [OP_W-1:0]   op_b;
   logic              last_q;
   logic [SC_W-1:0]   cnt;

   logic [ACC_W-1:0]  acc;
   logic              ovf;
   logic [CNT_W-1:0]  count;

   logic [PROD_W-1:0] product;
   logic [ACC_W:0]    sum_w;
   logic              carry;
   logic [CNT_W-1:0]  count_inc;

   logic              take_in;
   logic              settle_done;
   logic              take_out;

   vedic8x8 u_mult (
      .op_a    (op_a),
      .op_b    (op_b),
      .clk     (clk),
      .product (product)
   );

   // in_ready depends on state only, so a source may wait on it freely.
   assign bus.in_ready = (state == IDLE);

   assign sum_w     = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
   assign carry     = sum_w[ACC_W];
   assign count_inc = (count == CNT_MAX) ? count : count + 1'b1;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and the per-cycle strobes that steer the datapath.
   always_comb begin
      state_nx    = state;
      take_in     = 1'b0;
      settle_done = 1'b0;
      take_out    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.in_valid) begin
               take_in  = 1'b1;
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (cnt == SC_TC) begin
               settle_done = 1'b1;
               state_nx    = last_q ? OUT : IDLE;
            end
         end
         OUT: begin
            if (bus.out_valid && bus.out_ready) begin
               take_out = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture and settle counter; op_a/op_b only move on a handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a   <= '0;
         op_b   <= '0;
         last_q <= 1'b0;
         cnt    <= '0;
      end else if (take_in) begin
         op_a   <= bus.in_a;
         op_b   <= bus.in_b;
         last_q <= bus.in_last;
         cnt    <= '0;
      end else if (state == WAIT) begin
         cnt    <= cnt + 1'b1;
      end
   end

   // Group accumulator: running sum, sticky carry flag and product count.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         ovf   <= 1'b0;
         count <= '0;
      end else if (settle_done) begin
         if (last_q) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
         end else begin
            acc   <= sum_w[ACC_W-1:0];
            ovf   <= ovf | carry;
            count <= count_inc;
         end
      end
   end

   // Result registers; held after the handshake, qualified by out_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_acc   <= '0;
         bus.out_ovf   <= 1'b0;
         bus.out_count <= '0;
      end else if (settle_done && last_q) begin
         bus.out_valid <= 1'b1;
         bus.out_acc   <= sum_w[ACC_W-1:0];
         bus.out_ovf   <= ovf | carry;
         bus.out_count <= count_inc;
      end else if (take_out) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vedic_mac_seq.sv
// Bench for vedic_mac_seq: a 24-bit and a 16-bit accumulator instance
// share stimulus, selected per group by sel. Expected results come from
// plain integer arithmetic over each group's operand pairs.
module tb_vedic_mac_seq;
   import vedic_mac_seq_pkg::*;

   localparam int SETTLE = 11;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       in_valid;
   logic       in_last;
   logic       out_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   int         sel;

   vedic_mac_seq_if #(.ACC_W(24), .CNT_W(8)) ifc24 ();
   vedic_mac_seq_if #(.ACC_W(16), .CNT_W(8)) ifc16 ();

   vedic_mac_seq #(.SETTLE(SETTLE), .ACC_W(24), .CNT_W(8)) dut24 (
      .clk (clk),
      .rst (rst),
      .bus (ifc24.slave)
   );

   vedic_mac_seq #(.SETTLE(SETTLE), .ACC_W(16), .CNT_W(8)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (ifc16.slave)
   );

   assign ifc24.in_valid  = in_valid && (sel == 0);
   assign ifc24.in_a      = in_a;
   assign ifc24.in_b      = in_b;
   assign ifc24.in_last   = in_last;
   assign ifc24.out_ready = out_ready && (sel == 0);
   assign ifc16.in_valid  = in_valid && (sel == 1);
   assign ifc16.in_a      = in_a;
   assign ifc16.in_b      = in_b;
   assign ifc16.in_last   = in_last;
   assign ifc16.out_ready = out_ready && (sel == 1);

   logic        cur_in_ready;
   logic        cur_out_valid;
   logic        cur_ovf;
   logic [23:0] cur_acc;
   logic [7:0]  cur_count;

   always_comb begin
      if (sel == 0) begin
         cur_in_ready  = ifc24.in_ready;
         cur_out_valid = ifc24.out_valid;
         cur_ovf       = ifc24.out_ovf;
         cur_acc       = ifc24.out_acc;
         cur_count     = ifc24.out_count;
      end else begin
         cur_in_ready  = ifc16.in_ready;
         cur_out_valid = ifc16.out_valid;
         cur_ovf       = ifc16.out_ovf;
         cur_acc       = {8'h00, ifc16.out_acc};
         cur_count     = ifc16.out_count;
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      $display("FAIL %s: timed out, got no event, expected one within 200 cycles", name);
   endtask

   // Reference: group result from the list of products, by plain arithmetic.
   function automatic void model_group(input int w, input longint total, input int n,
                                       output longint eacc, output longint eovf,
                                       output longint ecnt);
      longint modv;
      modv = longint'(1) << w;
      eacc = total % modv;
      eovf = (total >= modv) ? 1 : 0;
      ecnt = (n > 255) ? 255 : n;
   endfunction

   task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last,
                            output int hs_cyc);
      int n;
      n        = 0;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      in_valid = 1'b1;
      while (!cur_in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cur_in_ready) begin
         timeout_fail("send_pair");
         in_valid = 1'b0;
         hs_cyc   = -1;
         return;
      end
      @(posedge clk); #1;
      hs_cyc   = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int vcyc);
      int n;
      n = 0;
      while (!cur_out_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cur_out_valid) begin
         timeout_fail("wait_valid");
         vcyc = -1;
      end else begin
         vcyc = cyc;
      end
   endtask

   task automatic take_result(input string name, input longint eacc, input longint eovf,
                              input longint ecnt, input int hold);
      int v;
      wait_valid(v);
      if (v < 0) return;
      repeat (hold) begin
         @(posedge clk); #1;
      end
      check({name, "_acc"},   cur_acc,   eacc);
      check({name, "_ovf"},   cur_ovf,   eovf);
      check({name, "_count"}, cur_count, ecnt);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, "_valid_clr"}, cur_out_valid, 0);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      int         exp_acc;
   } vec_t;

   vec_t vecs [7];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 1 ms");
      $fatal(1);
   end

   initial begin
      int     hs0, hs1, hs2, v, n;
      longint total, ea, eo, ec;
      logic [7:0] ra, rb;

      vecs[0] = '{8'd15,  8'd13,  195};
      vecs[1] = '{8'd0,   8'd200, 0};
      vecs[2] = '{8'd255, 8'd255, 65025};
      vecs[3] = '{8'd1,   8'd1,   1};
      vecs[4] = '{8'd200, 8'd0,   0};
      vecs[5] = '{8'd128, 8'd2,   256};
      vecs[6] = '{8'd17,  8'd19,  323};

      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; sel = 0; rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int s = 0; s < 2; s++) begin
         sel = s; #1;
         check("rst_in_ready",  cur_in_ready,  1);
         check("rst_out_valid", cur_out_valid, 0);
         check("rst_acc",       cur_acc,       0);
         check("rst_count",     cur_count,     0);
         check("rst_ovf",       cur_ovf,       0);
      end
      sel = 0; #1;

      // Single-pair groups with latency check.
      for (int i = 0; i < 7; i++) begin
         send_pair(vecs[i].a, vecs[i].b, 1'b1, hs0);
         wait_valid(v);
         if (hs0 >= 0 && v >= 0) check("latency", v - hs0, SETTLE);
         take_result("vec", vecs[i].exp_acc, 0, 1, 0);
      end

      // Three-pair group, back-to-back source: 12-cycle acceptance gap.
      send_pair(8'd255, 8'd255, 1'b0, hs0);
      send_pair(8'd255, 8'd255, 1'b0, hs1);
      send_pair(8'd1,   8'd1,   1'b1, hs2);
      check("gap01", hs1 - hs0, SETTLE + 1);
      check("gap12", hs2 - hs1, SETTLE + 1);
      take_result("grp3", 130051, 0, 3, 0);

      // 16-bit accumulator wrap, then a clean group.
      sel = 1; #1;
      send_pair(8'd255, 8'd255, 1'b0, hs0);
      send_pair(8'd255, 8'd255, 1'b1, hs0);
      take_result("wrap16", 64514, 1, 2, 0);
      send_pair(8'd2, 8'd3, 1'b1, hs0);
      take_result("after_wrap16", 6, 0, 1, 0);
      sel = 0; #1;

      // Result back-pressure.
      send_pair(8'd7, 8'd9, 1'b1, hs0);
      wait_valid(v);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_acc",       cur_acc,       63);
         check("bp_count",     cur_count,     1);
         check("bp_in_ready",  cur_in_ready,  0);
         check("bp_out_valid", cur_out_valid, 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_valid_clr", cur_out_valid, 0);
      check("bp_in_ready1", cur_in_ready,  1);
      check("bp_acc_kept",  cur_acc,       63);

      // Reset in the middle of a group's second pair.
      send_pair(8'd10, 8'd10, 1'b0, hs0);
      send_pair(8'd5,  8'd5,  1'b0, hs0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mrst_in_ready",  cur_in_ready,  1);
      check("mrst_out_valid", cur_out_valid, 0);
      check("mrst_acc",       cur_acc,       0);
      check("mrst_count",     cur_count,     0);
      check("mrst_ovf",       cur_ovf,       0);
      check("mrst_op_a",      dut24.op_a,    0);
      send_pair(8'd3, 8'd4, 1'b1, hs0);
      take_result("after_rst", 12, 0, 1, 0);

      // in_valid held with changing operands while the block is busy.
      send_pair(8'd0, 8'd200, 1'b1, hs0);
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_a = 8'($urandom_range(1, 255));
         in_b = 8'($urandom);
         in_last = 1'b0;
         @(posedge clk); #1;
         check("busy_in_ready", cur_in_ready, 0);
         check("busy_op_a",     dut24.op_a,   0);
      end
      in_valid = 1'b0;
      take_result("held", 0, 0, 1, 0);
      send_pair(8'd6, 8'd7, 1'b1, hs0);
      take_result("post_held", 42, 0, 1, 0);

      // Count saturation with 24-bit wrap.
      total = 0;
      for (int i = 0; i < 300; i++) begin
         send_pair(8'd255, 8'd255, (i == 299), hs0);
         total += 255 * 255;
      end
      model_group(24, total, 300, ea, eo, ec);
      take_result("sat", ea, eo, ec, 2);

      // Randomized groups on both widths.
      for (int g = 0; g < 24; g++) begin
         sel = int'($urandom_range(0, 1)); #1;
         n = int'($urandom_range(1, 6));
         total = 0;
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               ra = 8'($urandom_range(200, 255));
               rb = 8'($urandom_range(200, 255));
            end else begin
               ra = 8'($urandom);
               rb = 8'($urandom);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send_pair(ra, rb, (i == n - 1), hs0);
            total += longint'(ra) * longint'(rb);
         end
         model_group((sel == 0) ? 24 : 16, total, n, ea, eo, ec);
         take_result("rand", ea, eo, ec, int'($urandom_range(0, 4)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
